unified_mem_arbiter: RTL and testbench
======================================

# unified_mem_arbiter

Shares one single-ported unified instruction/data memory between the pipeline's IF stage (fetch, read-only) and MEM stage (load/store). It serializes the two request streams and drives the memory-side request/acknowledge handshake. It returns read data and one-cycle completion pulses to each requester, and produces stall levels that the hazard logic folds into `pc_write`, `IF_ID_write_en` and the pipeline-register enables. Data accesses have priority, with a starvation guard for fetch.

## Interface
- `ADDR_W`, 32, address width (byte address, passed through unchanged)
- `DATA_W`, 32, data width
- `MAX_DATA_STREAK`, 4, consecutive data grants allowed while a fetch is pending; must be ≥ 1

- `clk`  in  1  clock, rising edge
- `rst`  in  1  synchronous, active-low reset
- `if_req`  in  1  fetch request level, held until `if_done`
- `if_addr`  in  ADDR_W  fetch address, stable while `if_req`
- `if_cancel`  in  1  branch/jump flush of the current fetch
- `if_done`  out  1  one-cycle fetch completion pulse
- `if_rdata`  out  DATA_W  fetched instruction, valid with `if_done`, held afterward
- `if_stall`  out  1  `if_req & ~if_done`
- `dm_req`  in  1  data request level, held until `dm_done`
- `dm_we`  in  1  1 = store, 0 = load
- `dm_addr`  in  ADDR_W  data address
- `dm_wdata`  in  DATA_W  store data
- `dm_done`  out  1  one-cycle data completion pulse
- `dm_rdata`  out  DATA_W  load data, valid with `dm_done`, unchanged by stores
- `dm_stall`  out  1  `dm_req & ~dm_done`
- `mem_req`  out  1  memory request, held until `mem_ack`
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_ack`  in  1  one-cycle completion from memory, arbitrary latency ≥ 0 cycles after `mem_req` rises
- `mem_rdata`  in  DATA_W  read data, valid with `mem_ack`

## Operation
- States: IDLE, FETCH, DATA.
- **IDLE arbitration.** Eligible fetch means `if_req & ~if_done & ~if_cancel`. Eligible data means `dm_req & ~dm_done`.
  - If data is eligible and fetch is not, or the streak counter is below `MAX_DATA_STREAK`, go to DATA.
  - Otherwise, if fetch is eligible, go to FETCH.
  - On a grant, register `mem_req` = 1 and capture address, `we` and `wdata` (`we` = 0 for fetch).
- **Streak counter.**
  - Increments on each data grant made while an eligible fetch is pending.
  - Clears on any fetch grant, or on a data grant with no fetch pending.
  - Saturates at `MAX_DATA_STREAK`.
- **FETCH/DATA.** Hold `mem_*` stable until `mem_ack`. On the ack edge:
  - drop `mem_req` and `mem_we`;
  - return to IDLE;
  - register the rdata into the owner's `*_rdata` (loads and fetches only);
  - set the owner's `*_done` for one cycle.
- **Cancel.** `if_cancel` seen during FETCH sets a drop flag. On ack, `if_done` stays 0 and `if_rdata` is not updated. The memory transaction still completes. The drop flag clears on return to IDLE.
- The `~*_done` eligibility term prevents re-granting a requester in the cycle it sees its own done while its req is still high.
- **Reset** (`rst` = 0 at an edge), including mid-transaction:
  - state IDLE;
  - all outputs 0 (`mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `if_done`, `dm_done`, `if_rdata`, `dm_rdata`);
  - streak counter 0, drop flag 0.
  - The memory is reset in the same cycle; no ack is expected afterward.

## Timing
- Request first seen high in IDLE at cycle T → `mem_req` high in T+1.
- Ack in cycle A ≥ T+1 → `*_done` and rdata in A+1; state IDLE in A+1.
- Minimum access is 2 cycles (zero-wait memory).
- A new grant can be made in cycle A+1, so `mem_req` is high again in A+2. Back-to-back accesses therefore have one idle memory cycle.
- `mem_ack` while in IDLE is ignored.
- `if_stall` and `dm_stall` are combinational from inputs and registered done flags; there is no combinational path from `mem_ack`.
- Simultaneous `if_cancel` and ack in FETCH: drop wins, no `if_done`.

## Structure
- Shared package `mem_arb_pkg` contains:
  - state enum (IDLE/FETCH/DATA);
  - owner encoding (OWN_IF/OWN_DM);
  - default width constants.
- Single module; the streak counter and drop flag are inline. No sub-module is warranted.

## Test plan
- Fetch only, zero-wait memory: `if_req` at T, `if_addr` = 0x0000_0040, `mem_rdata` = 0x2008_0005 → `mem_req` at T+1, `if_done` at T+2 with `if_rdata` = 0x2008_0005.
- Both requesters at T, 3-cycle memory: data granted first (`mem_addr` = `dm_addr`). Fetch `mem_req` follows one idle cycle after `dm_done`.
- Store then load to 0x100 (wdata 0xDEAD_BEEF): `mem_we` = 1 on the first access. `dm_rdata` is unchanged at the store's `dm_done` and becomes 0xDEAD_BEEF at the load's `dm_done`.
- Continuous `dm_req` with `if_req` high, `MAX_DATA_STREAK` = 4 → exactly 4 data grants, then 1 fetch grant, then data again.
- `if_cancel` pulsed mid-fetch → `mem_ack` still consumed, no `if_done`, `if_rdata` holds its old value. The next fetch proceeds normally.
- `rst` = 0 while `mem_req` is high in DATA → next cycle all outputs are 0 and state is IDLE. No `dm_done` ever appears for the aborted access.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and default widths for the unified instruction/data memory
// arbiter: arbiter state encoding, grant owner encoding and width defaults.
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int DEF_ADDR_W          = 32;
  localparam int DEF_DATA_W          = 32;
  localparam int DEF_MAX_DATA_STREAK = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

endpackage : mem_arb_pkg

// File: rtl/unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// unified_mem_arbiter
// Serializes instruction fetches (IF stage, read-only) and data accesses
// (MEM stage, load/store) onto one single-ported memory with a req/ack
// handshake. Data has priority; a streak counter lets a pending fetch in
// after MAX_DATA_STREAK consecutive data grants.
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-low reset
//   if_req/if_addr    fetch request level and address, held until if_done
//   if_cancel         flush of the current fetch (result is dropped)
//   if_done/if_rdata  one-cycle fetch completion, fetched word (held)
//   if_stall          if_req & ~if_done
//   dm_req/dm_we/dm_addr/dm_wdata  data request, held until dm_done
//   dm_done/dm_rdata  one-cycle data completion, load data (held)
//   dm_stall          dm_req & ~dm_done
//   mem_req/mem_we/mem_addr/mem_wdata  memory request, held until mem_ack
//   mem_ack/mem_rdata one-cycle memory completion and read data
// -----------------------------------------------------------------------------
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int DATA_W          = DEF_DATA_W,
  parameter int MAX_DATA_STREAK = DEF_MAX_DATA_STREAK
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_cancel,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int                  STREAK_W   = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  arb_state_e          state_q;
  logic [STREAK_W-1:0] streak_q;
  logic                drop_q;

  logic   fetch_elig;
  logic   data_elig;
  logic   grant_valid;
  owner_e grant_owner;

  // The ~done terms keep a requester that still holds req in its done cycle
  // from being granted a second time for the same access.
  assign fetch_elig = if_req & ~if_done & ~if_cancel;
  assign data_elig  = dm_req & ~dm_done;

  assign if_stall = if_req & ~if_done;
  assign dm_stall = dm_req & ~dm_done;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    grant_valid = 1'b0;
    grant_owner = OWN_IF;
    if (data_elig && (!fetch_elig || streak_q < STREAK_MAX)) begin
      grant_valid = 1'b1;
      grant_owner = OWN_DM;
    end else if (fetch_elig) begin
      grant_valid = 1'b1;
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: read-data holding registers are plain flops, so they are reset
      // along with the control state; there is no storage array here.
      state_q   <= ST_IDLE;
      streak_q  <= '0;
      drop_q    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_done   <= 1'b0;
      dm_done   <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      // Completion flags are single-cycle pulses.
      if_done <= 1'b0;
      dm_done <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (grant_valid && grant_owner == OWN_DM) begin
            state_q   <= ST_DATA;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            // Count only grants that made a waiting fetch wait longer.
            if (!fetch_elig)
              streak_q <= '0;
            else if (streak_q != STREAK_MAX)
              streak_q <= streak_q + STREAK_W'(1);
          end else if (grant_valid) begin
            state_q   <= ST_FETCH;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            streak_q  <= '0;
          end
        end

        ST_FETCH: begin
          if (if_cancel)
            drop_q <= 1'b1;
          if (mem_ack) begin
            state_q <= ST_IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            drop_q  <= 1'b0;
            // A cancel arriving together with the ack still drops the word.
            if (!drop_q && !if_cancel) begin
              if_rdata <= mem_rdata;
              if_done  <= 1'b1;
            end
          end
        end

        ST_DATA: begin
          if (mem_ack) begin
            state_q <= ST_IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            dm_done <= 1'b1;
            if (!mem_we)
              dm_rdata <= mem_rdata;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule : unified_mem_arbiter

// File: tb/tb_unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_unified_mem_arbiter
// Self-checking bench: a behavioural memory with programmable latency, fetch
// and data requester tasks, and a scoreboard of expected grants and read data
// that a monitor pops as the arbiter issues requests and completions.
// -----------------------------------------------------------------------------
module tb_unified_mem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXS = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_cancel, if_done, if_stall;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          dm_req, dm_we, dm_done, dm_stall;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata, dm_rdata;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  unified_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_DATA_STREAK(MAXS)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
    .if_done(if_done), .if_rdata(if_rdata), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_done(dm_done), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- scoreboard
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } grant_t;

  grant_t        grant_q[$];
  logic [DW-1:0] if_q[$];
  logic [DW-1:0] dm_q[$];
  logic [DW-1:0] exp_if_last = '0;
  logic [DW-1:0] exp_dm_last = '0;

  task automatic push_grant(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    grant_t g;
    g.we = we; g.addr = a; g.wdata = d;
    grant_q.push_back(g);
  endtask

  task automatic exp_fetch(input logic [AW-1:0] a, input logic [DW-1:0] v);
    push_grant(1'b0, a, '0);
    if_q.push_back(v);
    exp_if_last = v;
  endtask

  task automatic exp_load(input logic [AW-1:0] a, input logic [DW-1:0] v);
    push_grant(1'b0, a, '0);
    dm_q.push_back(v);
    exp_dm_last = v;
  endtask

  // A store completes with dm_rdata unchanged from the last load.
  task automatic exp_store(input logic [AW-1:0] a, input logic [DW-1:0] d);
    push_grant(1'b1, a, d);
    dm_q.push_back(exp_dm_last);
  endtask

  // ------------------------------------------------------------ memory model
  logic [DW-1:0] mem [logic [AW-1:0]];
  int mem_lat  = 0;
  int wait_cnt = 0;
  int ack_cnt  = 0;

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
  end

  always @(negedge clk) begin
    if (!rst) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end else if (mem_ack) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end else if (mem_req) begin
      if (wait_cnt >= mem_lat) begin
        mem_ack = 1'b1;
        ack_cnt++;
        if (mem_we) mem[mem_addr] = mem_wdata;
        else        mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : '0;
      end else begin
        wait_cnt++;
      end
    end
  end

  // ----------------------------------------------------------------- monitor
  int     cyc = 0;
  int     last_rise_cyc = 0;
  int     last_dm_done_cyc = 0;
  logic   mem_req_d = 1'b0;
  logic   mon_en = 1'b0;
  grant_t mon_g;

  always @(posedge clk) begin
    cyc++;
    #2;
    if (rst && mon_en) begin
      check("if_stall", 32'(if_stall), 32'(if_req & ~if_done));
      check("dm_stall", 32'(dm_stall), 32'(dm_req & ~dm_done));
      if (mem_req && !mem_req_d) begin
        last_rise_cyc = cyc;
        if (grant_q.size() == 0) begin
          check("grant_unexpected", 32'(mem_req), 0);
        end else begin
          mon_g = grant_q.pop_front();
          check("grant_addr", mem_addr, mon_g.addr);
          check("grant_we", 32'(mem_we), 32'(mon_g.we));
          if (mon_g.we) check("grant_wdata", mem_wdata, mon_g.wdata);
        end
      end
      if (if_done) begin
        if (if_q.size() == 0) check("if_done_unexpected", 32'(if_done), 0);
        else                  check("if_rdata", if_rdata, if_q.pop_front());
      end
      if (dm_done) begin
        last_dm_done_cyc = cyc;
        if (dm_q.size() == 0) check("dm_done_unexpected", 32'(dm_done), 0);
        else                  check("dm_rdata", dm_rdata, dm_q.pop_front());
      end
    end
    mem_req_d = mem_req;
  end

  // --------------------------------------------------------------- requesters
  task automatic run_fetch(input logic [AW-1:0] a);
    bit seen = 1'b0;
    if_req  = 1'b1;
    if_addr = a;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = if_done;
    end
    if (!seen) check("if_timeout", 32'(if_done), 1);
    if_req = 1'b0;
  endtask

  task automatic run_data(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit seen = 1'b0;
    dm_req   = 1'b1;
    dm_we    = we;
    dm_addr  = a;
    dm_wdata = d;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = dm_done;
    end
    if (!seen) check("dm_timeout", 32'(dm_done), 1);
    dm_req = 1'b0;
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_mem_req"},   32'(mem_req),  0);
    check({pfx, "_mem_we"},    32'(mem_we),   0);
    check({pfx, "_mem_addr"},  mem_addr,      0);
    check({pfx, "_mem_wdata"}, mem_wdata,     0);
    check({pfx, "_if_done"},   32'(if_done),  0);
    check({pfx, "_dm_done"},   32'(dm_done),  0);
    check({pfx, "_if_rdata"},  if_rdata,      0);
    check({pfx, "_dm_rdata"},  dm_rdata,      0);
  endtask

  // -------------------------------------------------------------------- main
  bit streak_on = 1'b0;
  int ack_before;
  logic [DW-1:0] old_if;

  initial begin
    rst = 1'b0;
    if_req = 1'b0; if_addr = '0; if_cancel = 1'b0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;

    mem[32'h0000_0040] = 32'h2008_0005;
    mem[32'h0000_0044] = 32'h0000_0013;
    mem[32'h0000_0080] = 32'hCAFE_0080;
    mem[32'h0000_0200] = 32'h0200_0200;
    for (int i = 0; i < 5; i++) mem[32'h300 + 4*i] = 32'hA000_0000 + i;
    mem[32'h0000_0500] = 32'h1111_1111;
    mem[32'h0000_0504] = 32'h2222_2222;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // Fetch only, zero-wait: mem_req one cycle after the request, done one later.
    mem_lat = 0;
    exp_fetch(32'h40, 32'h2008_0005);
    if_req = 1'b1; if_addr = 32'h40;
    @(posedge clk); #2;
    check("t1_mem_req", 32'(mem_req), 1);
    check("t1_mem_addr", mem_addr, 32'h40);
    @(posedge clk); #2;
    check("t1_if_done", 32'(if_done), 1);
    check("t1_if_rdata", if_rdata, 32'h2008_0005);
    @(negedge clk);
    if_req = 1'b0;
    @(posedge clk); #2;
    check("t1_done_pulse", 32'(if_done), 0);
    check("t1_rdata_held", if_rdata, 32'h2008_0005);
    @(negedge clk);

    // Both requesters together, slow memory: data first, fetch one idle cycle later.
    mem_lat = 3;
    exp_load(32'h80, 32'hCAFE_0080);
    exp_fetch(32'h44, 32'h0000_0013);
    fork
      run_data(1'b0, 32'h80, '0);
      run_fetch(32'h44);
    join
    check("t2_idle_gap", last_rise_cyc - last_dm_done_cyc, 1);
    @(negedge clk);

    // Store then load to the same address.
    mem_lat = 1;
    exp_store(32'h100, 32'hDEAD_BEEF);
    run_data(1'b1, 32'h100, 32'hDEAD_BEEF);
    check("t3_store_keeps_rdata", dm_rdata, 32'hCAFE_0080);
    exp_load(32'h100, 32'hDEAD_BEEF);
    run_data(1'b0, 32'h100, '0);
    check("t3_load_rdata", dm_rdata, 32'hDEAD_BEEF);
    @(negedge clk);

    // Data streak: fetch is masked only in each data-done cycle, so it stays
    // pending at every arbitration point; after 4 data grants it gets in.
    mem_lat = 0;
    for (int i = 0; i < 4; i++) exp_load(32'h300 + 4*i, 32'hA000_0000 + i);
    exp_fetch(32'h200, 32'h0200_0200);
    exp_load(32'h310, 32'hA000_0004);
    streak_on = 1'b1;
    fork
      run_fetch(32'h200);
      begin
        for (int i = 0; i < 5; i++) run_data(1'b0, 32'h300 + 4*i, '0);
        streak_on = 1'b0;
      end
      begin
        while (streak_on) begin
          @(negedge clk);
          if_cancel = dm_done & streak_on;
        end
        if_cancel = 1'b0;
      end
    join
    check("t4_grants_left", grant_q.size(), 0);
    @(negedge clk);

    // Cancelled fetch: ack consumed, no done, rdata holds.
    mem_lat = 3;
    old_if = exp_if_last;
    ack_before = ack_cnt;
    push_grant(1'b0, 32'h500, '0);
    if_req = 1'b1; if_addr = 32'h500;
    @(negedge clk);
    if_cancel = 1'b1; if_req = 1'b0;
    @(negedge clk);
    if_cancel = 1'b0;
    repeat (8) @(negedge clk);
    check("t5_rdata_hold", if_rdata, old_if);
    check("t5_mem_idle", 32'(mem_req), 0);
    check("t5_ack_consumed", ack_cnt - ack_before, 1);
    exp_fetch(32'h504, 32'h2222_2222);
    run_fetch(32'h504);
    @(negedge clk);

    // Reset in the middle of a data access.
    mem_lat = 20;
    push_grant(1'b1, 32'h600, 32'h1234_5678);
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h600; dm_wdata = 32'h1234_5678;
    repeat (3) @(negedge clk);
    check("t6_busy", 32'(mem_req), 1);
    rst = 1'b0;
    exp_if_last = '0;
    exp_dm_last = '0;
    @(posedge clk); #2;
    check_all_zero("t6");
    @(negedge clk);
    dm_req = 1'b0; dm_we = 1'b0;
    rst = 1'b1;
    repeat (25) @(negedge clk);
    check("t6_still_idle", 32'(mem_req), 0);
    check("t6_grants_left", grant_q.size(), 0);

    // Arbiter is usable again after reset.
    mem_lat = 0;
    exp_fetch(32'h40, 32'h2008_0005);
    run_fetch(32'h40);
    repeat (2) @(negedge clk);
    check("end_if_q_empty", if_q.size(), 0);
    check("end_dm_q_empty", dm_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d checks run", tests_run);
    $fatal(1);
  end

endmodule : tb_unified_mem_arbiter
